frame_source_sequencer: RTL and testbench



---
 rtl/frame_source_sequencer_if.sv | 45 ++++
 rtl/frame_source_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_frame_source_sequencer.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_source_sequencer_if.sv
// Bus bundle between the frame sequencer and its environment: frame-start
// input, draw-source start/done handshakes, write-bus select and status flags.
interface frame_source_sequencer_if #(
    parameter int NUM_SOURCES      = 3,
    parameter int SOURCE_SEL_ADDRW = 2
);
    logic                        frame;
    logic [NUM_SOURCES-1:0]      src_enable;
    logic [NUM_SOURCES-1:0]      src_done;
    logic                        clear_flags;
    logic [NUM_SOURCES-1:0]      src_start;
    logic [SOURCE_SEL_ADDRW-1:0] write_source_sel;
    logic                        busy;
    logic                        frame_done;
    logic [NUM_SOURCES-1:0]      timeout_flags;
    logic                        overrun;

    // Sequencer side: consumes frame/handshake inputs, drives grants and status.
    modport master (
        input  frame,
        input  src_enable,
        input  src_done,
        input  clear_flags,
        output src_start,
        output write_source_sel,
        output busy,
        output frame_done,
        output timeout_flags,
        output overrun
    );

    // Environment side: frame manager and draw units.
    modport slave (
        output frame,
        output src_enable,
        output src_done,
        output clear_flags,
        input  src_start,
        input  write_source_sel,
        input  busy,
        input  frame_done,
        input  timeout_flags,
        input  overrun
    );
endinterface

// File: rtl/frame_source_sequencer.sv
// Per-frame draw-source sequencer. On each frame rising edge it grants the
// shared write bus to every enabled source in ascending index order (painter's
// order), waits for each source's done pulse or a watchdog timeout, then pulses
// frame_done. One extra frame edge can be queued; further edges while busy are
// dropped and flagged as overrun.
module frame_source_sequencer #(
    parameter int NUM_SOURCES      = 3,
    parameter int SOURCE_SEL_ADDRW = 2,
    parameter int TIMEOUT_CYCLES   = 420000,
    parameter int TIMEOUT_W        = 20
) (
    input  logic                     clk,
    input  logic                     resetN,
    frame_source_sequencer_if.master bus
);

    // idx must be able to reach NUM_SOURCES, the "all sources visited" marker.
    localparam int                   IDX_W     = $clog2(NUM_SOURCES + 1);
    localparam logic [IDX_W-1:0]     IDX_END   = IDX_W'(NUM_SOURCES);
    localparam logic [TIMEOUT_W-1:0] TIMER_MAX = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // One-hot mask for a source index; indices past the last source give zero.
    function automatic logic [NUM_SOURCES-1:0] onehot_f(input logic [IDX_W-1:0] idx);
        onehot_f = NUM_SOURCES'(1'b1) << idx;
    endfunction

    state_t                      state_r,         state_s;
    logic [IDX_W-1:0]            idx_r,           idx_s;
    logic [NUM_SOURCES-1:0]      en_q_r,          en_q_s;
    logic                        pending_r,       pending_s;
    logic                        frame_q_r;
    logic [TIMEOUT_W-1:0]        timer_r,         timer_s;
    logic [NUM_SOURCES-1:0]      src_start_r,     src_start_s;
    logic [SOURCE_SEL_ADDRW-1:0] sel_r,           sel_s;
    logic                        busy_r,          busy_s;
    logic                        frame_done_r,    frame_done_s;
    logic [NUM_SOURCES-1:0]      timeout_flags_r, timeout_flags_s;
    logic                        overrun_r,       overrun_s;

    logic                        fe_s;
    logic [NUM_SOURCES-1:0]      idx_mask_s;
    logic                        en_hit_s;
    logic                        done_hit_s;

    // Frame edge detect and per-index decode of the latched enable mask and done bus
    always_comb begin
        fe_s       = bus.frame & ~frame_q_r;
        idx_mask_s = onehot_f(idx_r);
        en_hit_s   = |(en_q_r & idx_mask_s);
        done_hit_s = |(bus.src_done & idx_mask_s);
    end

    // Next-state, queueing, watchdog and sticky-flag logic
    always_comb begin
        state_s     = state_r;
        idx_s       = idx_r;
        en_q_s      = en_q_r;
        pending_s   = pending_r;
        timer_s     = timer_r;
        src_start_s = '0;
        sel_s       = sel_r;

        // Clear first so that a set event in the same cycle overrides it.
        if (bus.clear_flags) begin
            timeout_flags_s = '0;
            overrun_s       = 1'b0;
        end else begin
            timeout_flags_s = timeout_flags_r;
            overrun_s       = overrun_r;
        end

        // Edges arriving mid-sequence (DONE included) are queued once, then dropped.
        if (fe_s && (state_r != ST_IDLE)) begin
            if (!pending_r) begin
                pending_s = 1'b1;
            end else begin
                overrun_s = 1'b1;
            end
        end else begin
            pending_s = pending_r;
        end

        case (state_r)
            ST_IDLE: begin
                // A frame queued during the DONE cycle itself is picked up here.
                if (fe_s || pending_r) begin
                    en_q_s    = bus.src_enable;
                    idx_s     = '0;
                    pending_s = fe_s & pending_r;
                    state_s   = ST_SCAN;
                end else begin
                    state_s   = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (idx_r == IDX_END) begin
                    state_s = ST_DONE;
                end else if (en_hit_s) begin
                    sel_s       = SOURCE_SEL_ADDRW'(idx_r);
                    src_start_s = idx_mask_s;
                    timer_s     = '0;
                    state_s     = ST_WAIT;
                end else begin
                    idx_s = idx_r + IDX_W'(1);
                end
            end
            ST_WAIT: begin
                // Done takes priority over a simultaneous timeout.
                if (done_hit_s) begin
                    idx_s   = idx_r + IDX_W'(1);
                    state_s = ST_SCAN;
                end else if (timer_r == TIMER_MAX) begin
                    timeout_flags_s = timeout_flags_s | idx_mask_s;
                    idx_s           = idx_r + IDX_W'(1);
                    state_s         = ST_SCAN;
                end else begin
                    timer_s = timer_r + TIMEOUT_W'(1);
                end
            end
            ST_DONE: begin
                sel_s = '0;
                // A queued frame restarts immediately without passing through IDLE.
                if (pending_r) begin
                    pending_s = 1'b0;
                    en_q_s    = bus.src_enable;
                    idx_s     = '0;
                    state_s   = ST_SCAN;
                end else begin
                    state_s   = ST_IDLE;
                end
            end
            default: begin
                idx_s   = '0;
                state_s = ST_IDLE;
            end
        endcase

        // Status outputs are registered copies of the state being entered.
        frame_done_s = (state_s == ST_DONE);
        busy_s       = (state_s != ST_IDLE);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_r         <= ST_IDLE;
            idx_r           <= '0;
            en_q_r          <= '0;
            pending_r       <= 1'b0;
            frame_q_r       <= 1'b0;
            timer_r         <= '0;
            src_start_r     <= '0;
            sel_r           <= '0;
            busy_r          <= 1'b0;
            frame_done_r    <= 1'b0;
            timeout_flags_r <= '0;
            overrun_r       <= 1'b0;
        end else begin
            state_r         <= state_s;
            idx_r           <= idx_s;
            en_q_r          <= en_q_s;
            pending_r       <= pending_s;
            frame_q_r       <= bus.frame;
            timer_r         <= timer_s;
            src_start_r     <= src_start_s;
            sel_r           <= sel_s;
            busy_r          <= busy_s;
            frame_done_r    <= frame_done_s;
            timeout_flags_r <= timeout_flags_s;
            overrun_r       <= overrun_s;
        end
    end

    assign bus.src_start        = src_start_r;
    assign bus.write_source_sel = sel_r;
    assign bus.busy             = busy_r;
    assign bus.frame_done       = frame_done_r;
    assign bus.timeout_flags    = timeout_flags_r;
    assign bus.overrun          = overrun_r;

endmodule

// File: tb/tb_frame_source_sequencer.sv
// Directed bench for frame_source_sequencer with a short watchdog (8 cycles).
// Time base: "rel" counts clock edges after the edge that samples the frame
// rising edge (rel 0); outputs are observed 1 ns after each rising edge.
module tb_frame_source_sequencer;

    logic clk;
    logic resetN;

    frame_source_sequencer_if #(.NUM_SOURCES(3), .SOURCE_SEL_ADDRW(2)) bus ();

    frame_source_sequencer #(
        .NUM_SOURCES      (3),
        .SOURCE_SEL_ADDRW (2),
        .TIMEOUT_CYCLES   (8),
        .TIMEOUT_W        (4)
    ) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus.master)
    );

    int errors = 0;
    int checks = 0;

    // Draw-unit model: source i answers dly[i] edges after its start pulse (0 = never).
    int         dly [3];
    int         cnt [3];
    logic [2:0] extra_done;
    logic [2:0] done_v;

    logic [2:0] exp_start;
    logic [1:0] exp_sel;
    logic       exp_fd;
    logic       exp_busy;
    logic       exp_ov;
    logic [2:0] exp_to;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            done_v[i] = 1'b0;
            if (bus.src_start[i]) cnt[i] = dly[i];
            if (cnt[i] > 0) begin
                cnt[i] = cnt[i] - 1;
                if (cnt[i] == 0) done_v[i] = 1'b1;
            end
        end
        bus.src_done = done_v | extra_done;
    endtask

    task automatic set_delays(input int d0, input int d1, input int d2);
        dly[0] = d0; dly[1] = d1; dly[2] = d2;
        for (int i = 0; i < 3; i++) cnt[i] = 0;
        extra_done = 3'b000;
    endtask

    task automatic start_frame();
        bus.frame = 1'b1;
        step();
        bus.frame = 1'b0;
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        step();
        step();
        if (bus.src_start !== 3'b000) begin errors++; $display("FAIL reset_start got=%b exp=000", bus.src_start); end
        checks++;
        if (bus.write_source_sel !== 2'd0) begin errors++; $display("FAIL reset_sel got=%0d exp=0", bus.write_source_sel); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++;
        if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got=%b exp=0", bus.frame_done); end
        checks++;
        if (bus.timeout_flags !== 3'b000) begin errors++; $display("FAIL reset_timeout got=%b exp=000", bus.timeout_flags); end
        checks++;
        if (bus.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", bus.overrun); end
        checks++;
        resetN = 1'b1;
        step();
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_busy got=%b exp=0", bus.busy); end
        checks++;
    endtask

    task automatic test_all_sources();
        set_delays(3, 3, 3);
        bus.src_enable = 3'b111;
        start_frame();
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL all_busy_rel0 got=%b exp=1", bus.busy); end
        checks++;
        for (int rel = 1; rel <= 15; rel++) begin
            step();
            exp_start = (rel == 1) ? 3'b001 : (rel == 5) ? 3'b010 : (rel == 9) ? 3'b100 : 3'b000;
            exp_sel   = (rel < 5) ? 2'd0 : (rel < 9) ? 2'd1 : (rel < 14) ? 2'd2 : 2'd0;
            exp_fd    = (rel == 13);
            exp_busy  = (rel <= 13);
            if (bus.src_start !== exp_start) begin errors++; $display("FAIL all_start rel=%0d got=%b exp=%b", rel, bus.src_start, exp_start); end
            checks++;
            if (bus.write_source_sel !== exp_sel) begin errors++; $display("FAIL all_sel rel=%0d got=%0d exp=%0d", rel, bus.write_source_sel, exp_sel); end
            checks++;
            if (bus.frame_done !== exp_fd) begin errors++; $display("FAIL all_frame_done rel=%0d got=%b exp=%b", rel, bus.frame_done, exp_fd); end
            checks++;
            if (bus.busy !== exp_busy) begin errors++; $display("FAIL all_busy rel=%0d got=%b exp=%b", rel, bus.busy, exp_busy); end
            checks++;
        end
    endtask

    task automatic test_skip_disabled();
        set_delays(1, 1, 1);
        bus.src_enable = 3'b101;
        start_frame();
        for (int rel = 1; rel <= 8; rel++) begin
            step();
            exp_start = (rel == 1) ? 3'b001 : (rel == 4) ? 3'b100 : 3'b000;
            exp_sel   = (rel < 4) ? 2'd0 : (rel < 7) ? 2'd2 : 2'd0;
            exp_fd    = (rel == 6);
            exp_busy  = (rel <= 6);
            if (bus.src_start !== exp_start) begin errors++; $display("FAIL skip_start rel=%0d got=%b exp=%b", rel, bus.src_start, exp_start); end
            checks++;
            if (bus.write_source_sel !== exp_sel) begin errors++; $display("FAIL skip_sel rel=%0d got=%0d exp=%0d", rel, bus.write_source_sel, exp_sel); end
            checks++;
            if (bus.frame_done !== exp_fd) begin errors++; $display("FAIL skip_frame_done rel=%0d got=%b exp=%b", rel, bus.frame_done, exp_fd); end
            checks++;
            if (bus.busy !== exp_busy) begin errors++; $display("FAIL skip_busy rel=%0d got=%b exp=%b", rel, bus.busy, exp_busy); end
            checks++;
        end
    endtask

    task automatic test_timeout();
        set_delays(1, 0, 1);
        bus.src_enable = 3'b111;
        start_frame();
        for (int rel = 1; rel <= 16; rel++) begin
            step();
            exp_start = (rel == 1) ? 3'b001 : (rel == 3) ? 3'b010 : (rel == 12) ? 3'b100 : 3'b000;
            exp_sel   = (rel < 3) ? 2'd0 : (rel < 12) ? 2'd1 : (rel < 15) ? 2'd2 : 2'd0;
            exp_to    = (rel >= 11) ? 3'b010 : 3'b000;
            exp_fd    = (rel == 14);
            exp_busy  = (rel <= 14);
            if (bus.src_start !== exp_start) begin errors++; $display("FAIL to_start rel=%0d got=%b exp=%b", rel, bus.src_start, exp_start); end
            checks++;
            if (bus.write_source_sel !== exp_sel) begin errors++; $display("FAIL to_sel rel=%0d got=%0d exp=%0d", rel, bus.write_source_sel, exp_sel); end
            checks++;
            if (bus.timeout_flags !== exp_to) begin errors++; $display("FAIL to_flags rel=%0d got=%b exp=%b", rel, bus.timeout_flags, exp_to); end
            checks++;
            if (bus.frame_done !== exp_fd) begin errors++; $display("FAIL to_frame_done rel=%0d got=%b exp=%b", rel, bus.frame_done, exp_fd); end
            checks++;
            if (bus.busy !== exp_busy) begin errors++; $display("FAIL to_busy rel=%0d got=%b exp=%b", rel, bus.busy, exp_busy); end
            checks++;
        end
    endtask

    task automatic test_overrun();
        bus.clear_flags = 1'b1;
        step();
        bus.clear_flags = 1'b0;
        if (bus.timeout_flags !== 3'b000) begin errors++; $display("FAIL clear_timeout got=%b exp=000", bus.timeout_flags); end
        checks++;
        set_delays(1, 1, 1);
        bus.src_enable = 3'b111;
        start_frame();
        for (int rel = 1; rel <= 17; rel++) begin
            step();
            exp_start = (rel == 1 || rel == 9)  ? 3'b001 :
                        (rel == 3 || rel == 11) ? 3'b010 :
                        (rel == 5 || rel == 13) ? 3'b100 : 3'b000;
            exp_fd    = (rel == 7 || rel == 15);
            exp_busy  = (rel <= 15);
            exp_ov    = (rel >= 4 && rel <= 16);
            if (bus.src_start !== exp_start) begin errors++; $display("FAIL ovr_start rel=%0d got=%b exp=%b", rel, bus.src_start, exp_start); end
            checks++;
            if (bus.frame_done !== exp_fd) begin errors++; $display("FAIL ovr_frame_done rel=%0d got=%b exp=%b", rel, bus.frame_done, exp_fd); end
            checks++;
            if (bus.busy !== exp_busy) begin errors++; $display("FAIL ovr_busy rel=%0d got=%b exp=%b", rel, bus.busy, exp_busy); end
            checks++;
            if (bus.overrun !== exp_ov) begin errors++; $display("FAIL ovr_flag rel=%0d got=%b exp=%b", rel, bus.overrun, exp_ov); end
            checks++;
            bus.frame       = (rel == 1 || rel == 3);
            bus.clear_flags = (rel == 16);
        end
        bus.clear_flags = 1'b0;
    endtask

    task automatic test_foreign_done();
        set_delays(4, 1, 1);
        bus.src_enable = 3'b111;
        start_frame();
        for (int rel = 1; rel <= 12; rel++) begin
            step();
            exp_start = (rel == 1) ? 3'b001 : (rel == 6) ? 3'b010 : (rel == 8) ? 3'b100 : 3'b000;
            exp_sel   = (rel < 6) ? 2'd0 : (rel < 8) ? 2'd1 : (rel < 11) ? 2'd2 : 2'd0;
            exp_fd    = (rel == 10);
            if (bus.src_start !== exp_start) begin errors++; $display("FAIL foreign_start rel=%0d got=%b exp=%b", rel, bus.src_start, exp_start); end
            checks++;
            if (bus.write_source_sel !== exp_sel) begin errors++; $display("FAIL foreign_sel rel=%0d got=%0d exp=%0d", rel, bus.write_source_sel, exp_sel); end
            checks++;
            if (bus.frame_done !== exp_fd) begin errors++; $display("FAIL foreign_frame_done rel=%0d got=%b exp=%b", rel, bus.frame_done, exp_fd); end
            checks++;
            extra_done = (rel == 1) ? 3'b100 : 3'b000;
        end
        if (bus.timeout_flags !== 3'b000) begin errors++; $display("FAIL foreign_timeout got=%b exp=000", bus.timeout_flags); end
        checks++;
    endtask

    task automatic test_reset_mid_sequence();
        set_delays(1, 0, 1);
        bus.src_enable = 3'b111;
        start_frame();
        for (int rel = 1; rel <= 4; rel++) begin
            step();
            exp_start = (rel == 1) ? 3'b001 : (rel == 3) ? 3'b010 : 3'b000;
            if (bus.src_start !== exp_start) begin errors++; $display("FAIL rst_mid_start rel=%0d got=%b exp=%b", rel, bus.src_start, exp_start); end
            checks++;
        end
        if (bus.write_source_sel !== 2'd1) begin errors++; $display("FAIL rst_mid_sel_before got=%0d exp=1", bus.write_source_sel); end
        checks++;
        resetN = 1'b0;
        step();
        resetN = 1'b1;
        if (bus.src_start !== 3'b000) begin errors++; $display("FAIL rst_mid_start_after got=%b exp=000", bus.src_start); end
        checks++;
        if (bus.write_source_sel !== 2'd0) begin errors++; $display("FAIL rst_mid_sel_after got=%0d exp=0", bus.write_source_sel); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy_after got=%b exp=0", bus.busy); end
        checks++;
        if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL rst_mid_fd_after got=%b exp=0", bus.frame_done); end
        checks++;
        for (int rel = 6; rel <= 11; rel++) begin
            step();
            if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL rst_mid_no_fd rel=%0d got=%b exp=0", rel, bus.frame_done); end
            checks++;
            if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_idle rel=%0d got=%b exp=0", rel, bus.busy); end
            checks++;
        end
        set_delays(1, 1, 1);
        start_frame();
        step();
        if (bus.src_start !== 3'b001) begin errors++; $display("FAIL restart_start got=%b exp=001", bus.src_start); end
        checks++;
        if (bus.write_source_sel !== 2'd0) begin errors++; $display("FAIL restart_sel got=%0d exp=0", bus.write_source_sel); end
        checks++;
        for (int rel = 2; rel <= 9; rel++) step();
    endtask

    initial begin
        resetN          = 1'b0;
        bus.frame       = 1'b0;
        bus.src_enable  = 3'b000;
        bus.src_done    = 3'b000;
        bus.clear_flags = 1'b0;
        set_delays(0, 0, 0);
        test_reset();
        test_all_sources();
        test_skip_disabled();
        test_timeout();
        test_overrun();
        test_foreign_done();
        test_reset_mid_sequence();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
